// File: rtl/bf16_pkg.sv
// Shared bf16 add/sub datapath constants and alignment-shifter state encoding.
package bf16_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MANT_W    = 8;
  localparam int unsigned GRS_W     = 3;
  localparam int unsigned SH_W      = MANT_W + 2;
  localparam int unsigned SAT_SHIFT = MANT_W + 2;
  localparam int unsigned AL_W      = MANT_W + GRS_W;
  localparam int unsigned CNT_W     = $clog2(SAT_SHIFT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } align_state_e;

endpackage

// File: rtl/fp_align_shifter_if.sv
// Operand/result handshake bundle for the pre-add alignment shifter.
interface fp_align_shifter_if;
  import bf16_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [EXP_W-1:0]  exp_a;
  logic [EXP_W-1:0]  exp_b;
  logic [MANT_W-1:0] mant_a;
  logic [MANT_W-1:0] mant_b;
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-1:0] mant_big;
  logic [AL_W-1:0]   mant_small_aligned;
  logic              swapped;

  modport master (
    output in_valid, exp_a, exp_b, mant_a, mant_b, out_ready,
    input  in_ready, out_valid, exp_out, mant_big, mant_small_aligned, swapped
  );

  modport slave (
    input  in_valid, exp_a, exp_b, mant_a, mant_b, out_ready,
    output in_ready, out_valid, exp_out, mant_big, mant_small_aligned, swapped
  );
endinterface

// File: rtl/fp_align_shifter.sv
// bf16 pre-add exponent alignment: orders operands by magnitude and right-shifts
// the smaller significand one bit per clock, keeping guard/round/sticky.
module fp_align_shifter
  import bf16_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  fp_align_shifter_if.slave bus
);

  logic              swap_c;
  logic [EXP_W-1:0]  exp_big_c;
  logic [EXP_W-1:0]  exp_small_c;
  logic [EXP_W-1:0]  diff_c;
  logic [MANT_W-1:0] mant_big_c;
  logic [MANT_W-1:0] mant_small_c;

  align_state_e      state;
  logic [CNT_W-1:0]  cnt;
  logic [SH_W-1:0]   sh;
  logic              sticky;
  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0] mant_big_q;
  logic              swapped_q;
  logic              out_valid_q;
  logic              in_ready_q;

  // Magnitude compare and operand ordering; ties on both fields keep a first.
  always_comb begin
    swap_c = (bus.exp_b > bus.exp_a) ||
             ((bus.exp_b == bus.exp_a) && (bus.mant_b > bus.mant_a));
    exp_big_c    = bus.exp_a;
    exp_small_c  = bus.exp_b;
    mant_big_c   = bus.mant_a;
    mant_small_c = bus.mant_b;
    if (swap_c) begin
      exp_big_c    = bus.exp_b;
      exp_small_c  = bus.exp_a;
      mant_big_c   = bus.mant_b;
      mant_small_c = bus.mant_a;
    end
    diff_c = exp_big_c - exp_small_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sh          <= '0;
      sticky      <= 1'b0;
      exp_q       <= '0;
      mant_big_q  <= '0;
      swapped_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            exp_q      <= exp_big_c;
            mant_big_q <= mant_big_c;
            swapped_q  <= swap_c;
            in_ready_q <= 1'b0;
            sh         <= {mant_small_c, 2'b00};
            sticky     <= 1'b0;
            if (diff_c == '0) begin
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
            end else if (diff_c >= EXP_W'(SAT_SHIFT)) begin
              // Everything falls off the end; only the sticky bit survives.
              sh          <= '0;
              sticky      <= |mant_small_c;
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
            end else begin
              cnt   <= CNT_W'(diff_c);
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          sticky <= sticky | sh[0];
          sh     <= sh >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready           = in_ready_q;
  assign bus.out_valid          = out_valid_q;
  assign bus.exp_out            = exp_q;
  assign bus.mant_big           = mant_big_q;
  assign bus.mant_small_aligned = {sh, sticky};
  assign bus.swapped            = swapped_q;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Directed and randomized checks of fp_align_shifter against an arithmetic reference model.
module tb_fp_align_shifter;
  import bf16_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_align_shifter_if bus ();
  fp_align_shifter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] sw;
    logic [31:0] e;
    logic [31:0] big;
    logic [31:0] al;
    logic [31:0] lat;
  } ref_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Alignment computed as integer arithmetic on the value {mant_small,00}.
  function automatic ref_t ref_model(input int ea, input int ma, input int eb, input int mb);
    ref_t r;
    int   sw, el, es, ml, ms, d, full, shv, st;
    sw = ((eb > ea) || (eb == ea && mb > ma)) ? 1 : 0;
    el = sw ? eb : ea;  es = sw ? ea : eb;
    ml = sw ? mb : ma;  ms = sw ? ma : mb;
    d = el - es;
    full = ms * 4;
    if (d >= 10) begin
      shv = 0;
      st  = (ms != 0) ? 1 : 0;
    end else begin
      shv = full >> d;
      st  = ((full % (1 << d)) != 0) ? 1 : 0;
    end
    r.sw  = 32'(sw);
    r.e   = 32'(el);
    r.big = 32'(ml);
    r.al  = 32'(shv * 2 + st);
    r.lat = (d == 0 || d >= 10) ? 32'd1 : 32'(d + 1);
    return r;
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic send(input string tag, input int ea, input int ma, input int eb, input int mb);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.exp_a = 8'(ea); bus.mant_a = 8'(ma);
    bus.exp_b = 8'(eb); bus.mant_b = 8'(mb);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid, then compare every result field.
  task automatic wait_result(input string tag, input ref_t r);
    int lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid === 1'b1) break;
    end
    chk({tag, "_latency"},   32'(lat), r.lat);
    chk({tag, "_swapped"},   32'(bus.swapped), r.sw);
    chk({tag, "_exp_out"},   32'(bus.exp_out), r.e);
    chk({tag, "_mant_big"},  32'(bus.mant_big), r.big);
    chk({tag, "_aligned"},   32'(bus.mant_small_aligned), r.al);
    chk({tag, "_in_ready0"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic release_out(input string tag, input int delay);
    repeat (delay) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input int ea, input int ma, input int eb, input int mb,
                        input int delay);
    ref_t r;
    r = ref_model(ea, ma, eb, mb);
    send(tag, ea, ma, eb, mb);
    wait_result(tag, r);
    release_out(tag, delay);
  endtask

  initial begin
    ref_t ra, rb;
    int   ea, eb, ma, mb, saw;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.exp_a = '0; bus.exp_b = '0; bus.mant_a = '0; bus.mant_b = '0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_exp_out",   32'(bus.exp_out), 32'd0);
    chk("rst_aligned",   32'(bus.mant_small_aligned), 32'd0);
    chk("rst_swapped",   32'(bus.swapped), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the known-answer list.
    ra = ref_model(8'h85, 8'hC0, 8'h82, 8'hA0);
    chk("t1_model", ra.al, 32'h0A0);
    run_op("t1", 8'h85, 8'hC0, 8'h82, 8'hA0, 0);
    run_op("t2", 8'h80, 8'h81, 8'h90, 8'h80, 1);
    run_op("t3", 8'h7F, 8'h90, 8'h7F, 8'hF0, 0);
    run_op("t4", 8'h89, 8'hC1, 8'h80, 8'hFF, 2);
    run_op("eq", 8'h40, 8'hAA, 8'h40, 8'hAA, 0);
    run_op("sat10", 8'h0A, 8'h80, 8'h00, 8'h01, 0);

    // Backpressure: outputs held, in_valid ignored, no accept in the handoff cycle.
    ra = ref_model(8'h90, 8'h85, 8'h8C, 8'hC3);
    rb = ref_model(8'h70, 8'hB1, 8'h75, 8'h9D);
    send("t5a", 8'h90, 8'h85, 8'h8C, 8'hC3);
    wait_result("t5a", ra);
    bus.exp_a = 8'h70; bus.mant_a = 8'hB1; bus.exp_b = 8'h75; bus.mant_b = 8'h9D;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      @(negedge clk);
      chk("t5_hold_valid",   32'(bus.out_valid), 32'd1);
      chk("t5_hold_aligned", 32'(bus.mant_small_aligned), ra.al);
      chk("t5_hold_exp",     32'(bus.exp_out), ra.e);
      chk("t5_hold_ready",   32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t5_handoff_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_handoff_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_result("t5b", rb);
    release_out("t5b", 0);

    // Reset during the third SHIFT cycle of a diff=8 operation.
    send("t6", 8'h88, 8'hF1, 8'h80, 8'hB7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",    32'(bus.out_valid), 32'd0);
    chk("t6_rst_exp",      32'(bus.exp_out), 32'd0);
    chk("t6_rst_big",      32'(bus.mant_big), 32'd0);
    chk("t6_rst_aligned",  32'(bus.mant_small_aligned), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) saw = 1;
    end
    chk("t6_no_stale", 32'(saw), 32'd0);
    chk("t6_ready",    32'(bus.in_ready), 32'd1);

    // Randomized operands, mostly with nearby exponents.
    for (int i = 0; i < 40; i++) begin
      ea = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) eb = ea;
      else eb = ea + int'($urandom_range(0, 26)) - 13;
      if (eb < 0) eb = 0;
      if (eb > 255) eb = 255;
      ma = int'($urandom_range(0, 255));
      mb = ($urandom_range(0, 4) == 0) ? ma : int'($urandom_range(0, 255));
      run_op("rnd", ea, ma, eb, mb, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
